v3a_queue_client: RTL and testbench
===================================

V3A_QUEUE_CLIENT -- requirements
Module: v3a_QueueClient

Interface
REQ-001 Parameters SHALL be: p_depth, default 32, queue entries; p_ptrwidth, default $clog2(p_depth), tag width; p_chanwidth, default 32, data width; p_timeout, default 64, max cycles an op enable is held.
REQ-002 Port clk, input, 1 bit: the single clock.
REQ-003 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port cmd_val, input, 1 bit: a command is offered.
REQ-005 Port cmd_rdy, output, 1 bit: the block can accept a command.
REQ-006 Port cmd_op, input, 3 bits: operation code; 0 ENQ_BACK, 1 ENQ_FRONT, 2 DEQ_FRONT, 3 DEQ_BACK, 4 UPD, 5 DEL, 6-7 illegal.
REQ-007 Port cmd_tag, input, p_ptrwidth bits: tag used by UPD and DEL.
REQ-008 Port cmd_data, input, p_chanwidth bits: payload used by ENQ_* and UPD.
REQ-009 Port resp_val, output, 1 bit, and resp_rdy, input, 1 bit: response handshake.
REQ-010 Port resp_op, output, 3 bits: echo of the accepted cmd_op.
REQ-011 Port resp_status, output, 3 bits: 0 OK, 1 TIMEOUT, 2 FULL, 3 EMPTY, 4 BADOP.
REQ-012 Port resp_tag, output, p_ptrwidth bits, and resp_data, output, p_chanwidth bits: returned tag and returned data.
REQ-013 Ports enq_back_en, enq_front_en, deq_front_en, deq_back_en, upd_en and del_en SHALL each be an output of 1 bit, driving the queue operation enables.
REQ-014 Ports enq_back_cpl, enq_front_cpl, deq_front_cpl, deq_back_cpl, upd_cpl and del_cpl SHALL each be an input of 1 bit, carrying the queue completions (registered in the queue).
REQ-015 Port enq_back_tag_out, input, and enq_front_tag_out, input, SHALL each be p_ptrwidth bits: tags returned by enqueues.
REQ-016 Port deq_front_data, input, and deq_back_data, input, SHALL each be p_chanwidth bits: data returned by dequeues.
REQ-017 Ports enq_back_data, enq_front_data and upd_data_in SHALL each be an output of p_chanwidth bits; ports upd_tag_in and del_tag_in SHALL each be an output of p_ptrwidth bits.
REQ-018 Port count, output, $clog2(p_depth+1) bits: client-side occupancy estimate.

Function
REQ-019 FSM SHALL have exactly three states: IDLE, ISSUE and RESP.
REQ-020 In IDLE, cmd_rdy=1 (and 0 in every other state); a transfer occurs on cmd_val&&cmd_rdy, latching op, tag and data.
REQ-021 On transfer, the next state SHALL be chosen as follows:
  - op 6-7: RESP with BADOP.
  - ENQ_* with count==p_depth: RESP with FULL.
  - DEQ_*, UPD or DEL with count==0: RESP with EMPTY.
  - otherwise: ISSUE, with timer cleared.
REQ-022 In ISSUE, exactly one enable (the one matching the latched op) SHALL be 1, gated combinationally low in any cycle its own cpl is 1, so the queue never fires twice.
REQ-023 Data and tag outputs SHALL equal the latched values for the entire ISSUE state; when not in ISSUE, they are 0.
REQ-024 In ISSUE, a cpl for the matching op SHALL produce RESP with OK, capturing these values:
  - ENQ_*: resp_tag from the matching *_tag_out.
  - DEQ_*: resp_data from the matching *_data.
  - UPD and DEL: resp_tag/resp_data as latched.
REQ-025 In ISSUE, a cpl for a non-matching op SHALL be ignored.
REQ-026 The timer SHALL increment each ISSUE cycle; when timer==p_timeout-1 with no matching cpl, the block SHALL go to RESP with TIMEOUT, so the enable is high exactly p_timeout cycles.
REQ-027 When a matching cpl and timer expiry occur in the same cycle, cpl SHALL win and the status is OK.
REQ-028 In RESP, resp_val=1 and all resp_* SHALL hold stable until resp_rdy=1, then the block returns to IDLE; at most one command is ever outstanding.
REQ-029 count SHALL increment on enq_back_cpl or enq_front_cpl, decrement on deq_front_cpl, deq_back_cpl or del_cpl, saturate at 0 and p_depth, and be unchanged on TIMEOUT, FULL, EMPTY or BADOP.
REQ-030 Latency: cmd accepted at T, enable high at T+1, earliest cpl at T+2, resp_val at T+3; rejected commands give resp_val at T+1.
REQ-031 After a response completes at cycle R, the next cmd_rdy=1 SHALL occur at R+1.

Reset
REQ-032 While rst=1, all enables and cmd_rdy SHALL be 0 combinationally; on the clock edge, state=IDLE, timer=0, count=0, resp_val=0, and resp_op/resp_status/resp_tag/resp_data=0.
REQ-033 A reset asserted mid-ISSUE or mid-RESP SHALL discard the command: enables drop in the reset cycle, no response is produced, and count returns to 0.

Verification
REQ-034 Reset, then ENQ_BACK data 0xA5 with the queue model returning tag 3 -> enq_back_en high 1 cycle, enq_back_data=0xA5, resp OK tag 3 at T+3, count=1.
REQ-035 After reset, DEQ_FRONT -> no enable ever high, resp EMPTY at T+1, count=0.
REQ-036 32 ENQ_BACK then a 33rd ENQ_FRONT -> first 32 responses OK with count=32, 33rd resp FULL, enq_front_en never high.
REQ-037 p_timeout=8 and a UPD tag 5 that is never completed -> upd_en high exactly 8 cycles with upd_tag_in=5, resp TIMEOUT, count unchanged.
REQ-038 Hold resp_rdy=0 for 5 cycles after resp_val -> resp_* stable and cmd_rdy=0 throughout, then IDLE one cycle after resp_rdy=1.
REQ-039 Assert rst during ISSUE of DEL -> del_en 0 in that cycle, resp_val never asserted, count=0, cmd_rdy=1 the cycle after rst falls.

Source files
------------

// File: rtl/v3a_queue_client.sv
// Single-outstanding command client for a tagged double-ended queue.
// It accepts one command, drives the matching queue enable until the
// queue completes or the timeout expires, then holds a response until
// it is taken.
module v3a_queue_client #(
  parameter int unsigned p_depth     = 32,
  parameter int unsigned p_ptrwidth  = $clog2(p_depth),
  parameter int unsigned p_chanwidth = 32,
  parameter int unsigned p_timeout   = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  // Command channel
  input  logic                           cmd_val,
  output logic                           cmd_rdy,
  input  logic [2:0]                     cmd_op,
  input  logic [p_ptrwidth-1:0]          cmd_tag,
  input  logic [p_chanwidth-1:0]         cmd_data,
  // Response channel
  output logic                           resp_val,
  input  logic                           resp_rdy,
  output logic [2:0]                     resp_op,
  output logic [2:0]                     resp_status,
  output logic [p_ptrwidth-1:0]          resp_tag,
  output logic [p_chanwidth-1:0]         resp_data,
  // Queue operation enables
  output logic                           enq_back_en,
  output logic                           enq_front_en,
  output logic                           deq_front_en,
  output logic                           deq_back_en,
  output logic                           upd_en,
  output logic                           del_en,
  // Queue completions
  input  logic                           enq_back_cpl,
  input  logic                           enq_front_cpl,
  input  logic                           deq_front_cpl,
  input  logic                           deq_back_cpl,
  input  logic                           upd_cpl,
  input  logic                           del_cpl,
  // Queue return values
  input  logic [p_ptrwidth-1:0]          enq_back_tag_out,
  input  logic [p_ptrwidth-1:0]          enq_front_tag_out,
  input  logic [p_chanwidth-1:0]         deq_front_data,
  input  logic [p_chanwidth-1:0]         deq_back_data,
  // Queue operation arguments
  output logic [p_chanwidth-1:0]         enq_back_data,
  output logic [p_chanwidth-1:0]         enq_front_data,
  output logic [p_chanwidth-1:0]         upd_data_in,
  output logic [p_ptrwidth-1:0]          upd_tag_in,
  output logic [p_ptrwidth-1:0]          del_tag_in,
  // Occupancy estimate
  output logic [$clog2(p_depth+1)-1:0]   count
);

  localparam int unsigned CntW = $clog2(p_depth + 1);
  localparam int unsigned TmrW = (p_timeout > 1) ? $clog2(p_timeout) : 1;

  localparam logic [2:0] OpEnqBack  = 3'd0;
  localparam logic [2:0] OpEnqFront = 3'd1;
  localparam logic [2:0] OpDeqFront = 3'd2;
  localparam logic [2:0] OpDeqBack  = 3'd3;
  localparam logic [2:0] OpUpd      = 3'd4;
  localparam logic [2:0] OpDel      = 3'd5;

  localparam logic [2:0] StsOk      = 3'd0;
  localparam logic [2:0] StsTimeout = 3'd1;
  localparam logic [2:0] StsFull    = 3'd2;
  localparam logic [2:0] StsEmpty   = 3'd3;
  localparam logic [2:0] StsBadop   = 3'd4;

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e                 state_q, state_d;
  logic [2:0]             op_q;
  logic [p_ptrwidth-1:0]  tag_q;
  logic [p_chanwidth-1:0] data_q;
  logic [TmrW-1:0]        timer_q;
  logic [CntW-1:0]        count_q, count_d;
  logic [2:0]             resp_op_q, resp_op_d;
  logic [2:0]             resp_status_q, resp_status_d;
  logic [p_ptrwidth-1:0]  resp_tag_q, resp_tag_d;
  logic [p_chanwidth-1:0] resp_data_q, resp_data_d;

  logic cmd_fire;
  logic cpl_match;
  logic is_issue;
  logic op_is_enq_q;
  logic op_is_dec_q;

  assign cmd_fire    = cmd_val && cmd_rdy;
  assign is_issue    = (state_q == StIssue);
  assign op_is_enq_q = (op_q == OpEnqBack) || (op_q == OpEnqFront);
  assign op_is_dec_q = (op_q == OpDeqFront) || (op_q == OpDeqBack) || (op_q == OpDel);

  // Select the completion belonging to the latched operation; others are ignored.
  always_comb begin
    cpl_match = 1'b0;
    case (op_q)
      OpEnqBack:  cpl_match = enq_back_cpl;
      OpEnqFront: cpl_match = enq_front_cpl;
      OpDeqFront: cpl_match = deq_front_cpl;
      OpDeqBack:  cpl_match = deq_back_cpl;
      OpUpd:      cpl_match = upd_cpl;
      OpDel:      cpl_match = del_cpl;
      default:    cpl_match = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, response capture and occupancy update.
  always_comb begin
    state_d       = state_q;
    resp_op_d     = resp_op_q;
    resp_status_d = resp_status_q;
    resp_tag_d    = resp_tag_q;
    resp_data_d   = resp_data_q;
    count_d       = count_q;
    case (state_q)
      StIdle: begin
        if (cmd_fire) begin
          resp_op_d     = cmd_op;
          resp_tag_d    = cmd_tag;
          resp_data_d   = cmd_data;
          resp_status_d = StsOk;
          if (cmd_op > OpDel) begin
            state_d       = StResp;
            resp_status_d = StsBadop;
          end else if ((cmd_op == OpEnqBack) || (cmd_op == OpEnqFront)) begin
            if (count_q == CntW'(p_depth)) begin
              state_d       = StResp;
              resp_status_d = StsFull;
            end else begin
              state_d = StIssue;
            end
          end else if (count_q == '0) begin
            state_d       = StResp;
            resp_status_d = StsEmpty;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        // A completion in the expiry cycle still counts as success.
        if (cpl_match) begin
          state_d       = StResp;
          resp_status_d = StsOk;
          case (op_q)
            OpEnqBack:  resp_tag_d  = enq_back_tag_out;
            OpEnqFront: resp_tag_d  = enq_front_tag_out;
            OpDeqFront: resp_data_d = deq_front_data;
            OpDeqBack:  resp_data_d = deq_back_data;
            default:    ;
          endcase
          if (op_is_enq_q && (count_q != CntW'(p_depth))) begin
            count_d = count_q + 1'b1;
          end else if (op_is_dec_q && (count_q != '0)) begin
            count_d = count_q - 1'b1;
          end
        end else if (timer_q == TmrW'(p_timeout - 1)) begin
          state_d       = StResp;
          resp_status_d = StsTimeout;
        end
      end
      StResp: begin
        if (resp_rdy) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Command latch, issue timer, occupancy and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q          <= '0;
      tag_q         <= '0;
      data_q        <= '0;
      timer_q       <= '0;
      count_q       <= '0;
      resp_op_q     <= '0;
      resp_status_q <= '0;
      resp_tag_q    <= '0;
      resp_data_q   <= '0;
    end else begin
      if (cmd_fire) begin
        op_q   <= cmd_op;
        tag_q  <= cmd_tag;
        data_q <= cmd_data;
      end
      // Held at zero outside ISSUE so every issue starts from a cleared timer.
      timer_q       <= is_issue ? timer_q + 1'b1 : '0;
      count_q       <= count_d;
      resp_op_q     <= resp_op_d;
      resp_status_q <= resp_status_d;
      resp_tag_q    <= resp_tag_d;
      resp_data_q   <= resp_data_d;
    end
  end

  // Handshakes, queue enables and queue arguments.
  always_comb begin
    cmd_rdy  = !rst && (state_q == StIdle);
    resp_val = !rst && (state_q == StResp);
    // Each enable drops in the cycle its own completion arrives so the queue fires once.
    enq_back_en  = !rst && is_issue && (op_q == OpEnqBack)  && !enq_back_cpl;
    enq_front_en = !rst && is_issue && (op_q == OpEnqFront) && !enq_front_cpl;
    deq_front_en = !rst && is_issue && (op_q == OpDeqFront) && !deq_front_cpl;
    deq_back_en  = !rst && is_issue && (op_q == OpDeqBack)  && !deq_back_cpl;
    upd_en       = !rst && is_issue && (op_q == OpUpd)      && !upd_cpl;
    del_en       = !rst && is_issue && (op_q == OpDel)      && !del_cpl;
    enq_back_data  = is_issue ? data_q : '0;
    enq_front_data = is_issue ? data_q : '0;
    upd_data_in    = is_issue ? data_q : '0;
    upd_tag_in     = is_issue ? tag_q  : '0;
    del_tag_in     = is_issue ? tag_q  : '0;
  end

  assign resp_op     = resp_op_q;
  assign resp_status = resp_status_q;
  assign resp_tag    = resp_tag_q;
  assign resp_data   = resp_data_q;
  assign count       = count_q;

endmodule

// File: tb/tb_v3a_queue_client.sv
// Directed bench for v3a_queue_client with a small responding queue model,
// a scoreboard of expected responses and a separate response monitor.
module tb_v3a_queue_client;

  localparam int unsigned Depth = 32;
  localparam int unsigned PW    = 5;
  localparam int unsigned CW    = 32;
  localparam int unsigned TO    = 8;
  localparam int unsigned CntW  = 6;

  localparam logic [2:0] OpEnqBack  = 3'd0;
  localparam logic [2:0] OpEnqFront = 3'd1;
  localparam logic [2:0] OpDeqFront = 3'd2;
  localparam logic [2:0] OpDeqBack  = 3'd3;
  localparam logic [2:0] OpUpd      = 3'd4;
  localparam logic [2:0] OpDel      = 3'd5;

  localparam logic [2:0] StsOk      = 3'd0;
  localparam logic [2:0] StsTimeout = 3'd1;
  localparam logic [2:0] StsFull    = 3'd2;
  localparam logic [2:0] StsEmpty   = 3'd3;
  localparam logic [2:0] StsBadop   = 3'd4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_val = 1'b0;
  logic cmd_rdy;
  logic [2:0] cmd_op = '0;
  logic [PW-1:0] cmd_tag = '0;
  logic [CW-1:0] cmd_data = '0;
  logic resp_val;
  logic resp_rdy = 1'b1;
  logic [2:0] resp_op, resp_status;
  logic [PW-1:0] resp_tag;
  logic [CW-1:0] resp_data;
  logic enq_back_en, enq_front_en, deq_front_en, deq_back_en, upd_en, del_en;
  logic enq_back_cpl = 1'b0, enq_front_cpl = 1'b0, deq_front_cpl = 1'b0;
  logic deq_back_cpl = 1'b0, upd_cpl = 1'b0, del_cpl = 1'b0;
  logic [PW-1:0] m_back_tag = '0, m_front_tag = '0;
  logic [CW-1:0] m_front_data = '0, m_back_data = '0;
  logic [CW-1:0] enq_back_data, enq_front_data, upd_data_in;
  logic [PW-1:0] upd_tag_in, del_tag_in;
  logic [CntW-1:0] count;
  logic [5:0] ens;

  v3a_queue_client #(
    .p_depth    (Depth),
    .p_ptrwidth (PW),
    .p_chanwidth(CW),
    .p_timeout  (TO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_val          (cmd_val),
    .cmd_rdy          (cmd_rdy),
    .cmd_op           (cmd_op),
    .cmd_tag          (cmd_tag),
    .cmd_data         (cmd_data),
    .resp_val         (resp_val),
    .resp_rdy         (resp_rdy),
    .resp_op          (resp_op),
    .resp_status      (resp_status),
    .resp_tag         (resp_tag),
    .resp_data        (resp_data),
    .enq_back_en      (enq_back_en),
    .enq_front_en     (enq_front_en),
    .deq_front_en     (deq_front_en),
    .deq_back_en      (deq_back_en),
    .upd_en           (upd_en),
    .del_en           (del_en),
    .enq_back_cpl     (enq_back_cpl),
    .enq_front_cpl    (enq_front_cpl),
    .deq_front_cpl    (deq_front_cpl),
    .deq_back_cpl     (deq_back_cpl),
    .upd_cpl          (upd_cpl),
    .del_cpl          (del_cpl),
    .enq_back_tag_out (m_back_tag),
    .enq_front_tag_out(m_front_tag),
    .deq_front_data   (m_front_data),
    .deq_back_data    (m_back_data),
    .enq_back_data    (enq_back_data),
    .enq_front_data   (enq_front_data),
    .upd_data_in      (upd_data_in),
    .upd_tag_in       (upd_tag_in),
    .del_tag_in       (del_tag_in),
    .count            (count)
  );

  assign ens = {del_en, upd_en, deq_back_en, deq_front_en, enq_front_en, enq_back_en};

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int t_acc = 0;
  int en_hi [6];

  typedef struct {
    logic [2:0]    op;
    logic [2:0]    st;
    logic [PW-1:0] tag;
    logic [CW-1:0] data;
    bit            ct;
    bit            cd;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] op, input logic [2:0] st, input logic [PW-1:0] tag,
                      input logic [CW-1:0] data, input bit ct, input bit cd);
    exp_t e;
    e.op = op; e.st = st; e.tag = tag; e.data = data; e.ct = ct; e.cd = cd;
    sb.push_back(e);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Queue model: completion is registered, optionally after model_delay extra enable cycles.
  bit model_on = 1'b1;
  int model_delay = 0;
  int hold = 0;
  always @(posedge clk) begin
    if (rst || (ens == '0)) hold <= 0;
    else hold <= hold + 1;
    enq_back_cpl  <= model_on && enq_back_en  && (hold == model_delay);
    enq_front_cpl <= model_on && enq_front_en && (hold == model_delay);
    deq_front_cpl <= model_on && deq_front_en && (hold == model_delay);
    deq_back_cpl  <= model_on && deq_back_en  && (hold == model_delay);
    upd_cpl       <= model_on && upd_en       && (hold == model_delay);
    del_cpl       <= model_on && del_en       && (hold == model_delay);
  end

  // Count cycles each enable is high.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 6; i++) if (ens[i]) en_hi[i]++;
  end

  // Response monitor: every completed response handshake is checked against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && resp_val && resp_rdy) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_resp: got op %0d status %0d, required no response",
                 resp_op, resp_status);
      end else begin
        e = sb.pop_front();
        chk("resp_op", resp_op, e.op);
        chk("resp_status", resp_status, e.st);
        if (e.ct) chk("resp_tag", resp_tag, e.tag);
        if (e.cd) chk("resp_data", resp_data, e.data);
      end
    end
  end

  task automatic clear_en();
    @(negedge clk);
    for (int i = 0; i < 6; i++) en_hi[i] = 0;
  endtask

  task automatic start(input logic [2:0] op, input logic [PW-1:0] tag, input logic [CW-1:0] data);
    int n = 0;
    @(negedge clk);
    while (!cmd_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_rdy) chk("cmd_rdy_wait", cmd_rdy, 1);
    cmd_val  = 1'b1;
    cmd_op   = op;
    cmd_tag  = tag;
    cmd_data = data;
    t_acc    = cyc;
    @(posedge clk);
    #1;
    cmd_val = 1'b0;
  endtask

  task automatic wait_resp(input int exp_lat);
    int n = 0;
    while (!resp_val && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("resp_latency", cyc - t_acc, exp_lat);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  logic [63:0] snap;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 6; i++) en_hi[i] = 0;
    // Reset state
    repeat (3) @(negedge clk);
    cmd_val = 1'b1;
    #1;
    chk("rst_cmd_rdy", cmd_rdy, 0);
    chk("rst_enables", ens, 0);
    cmd_val = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_cmd_rdy", cmd_rdy, 1);
    chk("reset_resp_val", resp_val, 0);
    chk("reset_count", count, 0);
    chk("reset_resp_fields", {resp_op, resp_status, resp_tag, resp_data}, 0);

    // DEQ_FRONT on empty queue
    clear_en();
    push(OpDeqFront, StsEmpty, '0, '0, 0, 0);
    start(OpDeqFront, '0, '0);
    wait_resp(1);
    chk("empty_count", count, 0);
    settle();
    chk("empty_no_enable", en_hi[0] + en_hi[1] + en_hi[2] + en_hi[3] + en_hi[4] + en_hi[5], 0);

    // ENQ_BACK 0xA5, queue returns tag 3
    clear_en();
    m_back_tag = 5'd3;
    push(OpEnqBack, StsOk, 5'd3, '0, 1, 0);
    start(OpEnqBack, 5'd0, 32'hA5);
    chk("enq_back_en_t1", enq_back_en, 1);
    chk("enq_back_data", enq_back_data, 32'hA5);
    wait_resp(3);
    chk("enq_count", count, 1);
    settle();
    chk("enq_back_en_cycles", en_hi[0], 1);
    chk("enq_back_data_idle", enq_back_data, 0);

    // DEQ_FRONT returns queue data
    m_front_data = 32'h1234_5678;
    push(OpDeqFront, StsOk, '0, 32'h1234_5678, 0, 1);
    start(OpDeqFront, '0, '0);
    wait_resp(3);
    chk("deq_count", count, 0);

    // Illegal op, then UPD on empty
    push(3'd7, StsBadop, '0, '0, 0, 0);
    start(3'd7, '0, '0);
    wait_resp(1);
    push(OpUpd, StsEmpty, '0, '0, 0, 0);
    start(OpUpd, 5'd1, 32'h1);
    wait_resp(1);

    // ENQ_FRONT returns tag 7
    m_front_tag = 5'd7;
    push(OpEnqFront, StsOk, 5'd7, '0, 1, 0);
    start(OpEnqFront, '0, 32'h55);
    chk("enq_front_data", enq_front_data, 32'h55);
    wait_resp(3);
    chk("enq_front_count", count, 1);

    // UPD tag 5 never completed: timeout after exactly TO enable cycles
    model_on = 1'b0;
    clear_en();
    push(OpUpd, StsTimeout, '0, '0, 0, 0);
    start(OpUpd, 5'd5, 32'h99);
    chk("upd_tag_in", upd_tag_in, 5);
    chk("upd_data_in", upd_data_in, 32'h99);
    wait_resp(1 + TO);
    chk("timeout_count", count, 1);
    settle();
    chk("upd_en_cycles", en_hi[4], TO);
    chk("upd_tag_idle", upd_tag_in, 0);
    model_on = 1'b1;

    // UPD completed: latched tag/data echoed
    push(OpUpd, StsOk, 5'd5, 32'h77, 1, 1);
    start(OpUpd, 5'd5, 32'h77);
    wait_resp(3);
    chk("upd_count", count, 1);

    // Completion in the same cycle as expiry wins
    model_delay = TO - 2;
    m_back_tag = 5'd9;
    clear_en();
    push(OpEnqBack, StsOk, 5'd9, '0, 1, 0);
    start(OpEnqBack, '0, 32'h3C);
    wait_resp(1 + TO);
    chk("tie_count", count, 2);
    settle();
    chk("tie_en_cycles", en_hi[0], TO - 1);
    model_delay = 0;

    // DEL tag 2 with response back-pressure for 5 cycles
    resp_rdy = 1'b0;
    push(OpDel, StsOk, 5'd2, '0, 1, 0);
    start(OpDel, 5'd2, '0);
    chk("del_tag_in", del_tag_in, 2);
    wait_resp(3);
    snap = {21'd0, resp_op, resp_status, resp_tag, resp_data};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("hold_fields", {21'd0, resp_op, resp_status, resp_tag, resp_data}, snap);
      chk("hold_cmd_rdy", cmd_rdy, 0);
      chk("hold_resp_val", resp_val, 1);
    end
    resp_rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("release_cmd_rdy", cmd_rdy, 1);
    chk("release_resp_val", resp_val, 0);
    chk("del_count", count, 1);

    // Fill to depth, then ENQ_FRONT is FULL
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rerst_count", count, 0);
    for (int i = 0; i < Depth; i++) begin
      m_back_tag = PW'(i);
      push(OpEnqBack, StsOk, PW'(i), '0, 1, 0);
      start(OpEnqBack, '0, CW'(i));
      wait_resp(3);
    end
    chk("full_count", count, Depth);
    clear_en();
    push(OpEnqFront, StsFull, '0, '0, 0, 0);
    start(OpEnqFront, '0, 32'hF);
    wait_resp(1);
    settle();
    chk("full_no_enable", en_hi[1], 0);
    chk("full_count_kept", count, Depth);

    // DEQ_BACK from full queue
    m_back_data = 32'hCAFE_F00D;
    push(OpDeqBack, StsOk, '0, 32'hCAFE_F00D, 0, 1);
    start(OpDeqBack, '0, '0);
    wait_resp(3);
    chk("deq_back_count", count, Depth - 1);

    // Reset during ISSUE of DEL: command discarded, no response
    model_on = 1'b0;
    start(OpDel, 5'd4, '0);
    chk("del_en_issue", del_en, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("del_en_in_rst", del_en, 0);
    @(negedge clk);
    rst = 1'b0;
    model_on = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_cmd_rdy", cmd_rdy, 1);
    chk("post_rst_count", count, 0);
    chk("post_rst_resp_val", resp_val, 0);
    repeat (10) @(posedge clk);

    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
